mm2s_byte_packetizer: RTL and testbench
=======================================

MM2S_BYTE_PACKETIZER -- requirements
Module: mm2s_byte_packetizer

Interface
REQ-001 Parameter PKT_WORDS, default 64, SHALL set the maximum number of 64-bit input words per packet; legal range 1..8191.
REQ-002 Parameter HDR_MAGIC, default 16'hA55A, SHALL set the two-byte packet start marker.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata  in  64  datamover MM2S read data; byte lane 0 is [7:0].
REQ-006 s_axis_tkeep  in  8  byte-lane qualifiers.
REQ-007 s_axis_tlast  in  1  end of the datamover transfer.
REQ-008 s_axis_tvalid  in  1  input word valid.
REQ-009 s_axis_tready  out  1  input word accepted when high together with tvalid.
REQ-010 m_axis_tdata  out  8  byte stream toward the Ethernet MAC.
REQ-011 m_axis_tvalid  out  1  output byte valid.
REQ-012 m_axis_tlast  out  1  high on the final trailer byte of each packet.
REQ-013 m_axis_tready  in  1  MAC back-pressure; may be low for arbitrary periods.

Function
REQ-014 Packet format SHALL be: HDR_MAGIC[15:8], HDR_MAGIC[7:0], seq[15:8], seq[7:0], payload bytes, then the trailer.
REQ-015 FSM states SHALL be IDLE, HDR, PAYLOAD and TRL; IDLE->HDR on s_axis_tvalid; HDR->PAYLOAD after the 4th header byte handshake; PAYLOAD->TRL on close; TRL->IDLE after the m_axis_tlast handshake.
REQ-016 The first header byte SHALL present m_axis_tvalid on the cycle after s_axis_tvalid is sampled in IDLE.
REQ-017 s_axis_tready SHALL be high only in PAYLOAD while the internal word register is empty; it SHALL NOT depend combinationally on m_axis_tready.
REQ-018 An accepted word SHALL be serialised lane 0 to lane 7, with lanes where tkeep=0 skipped; at most one byte per cycle.
REQ-019 A word with tkeep=8'h00 SHALL emit no bytes and SHALL still count toward PKT_WORDS.
REQ-020 A packet SHALL close after the last byte of the word that is the PKT_WORDS-th word or that carries tlast; if both hold on the same word, it SHALL close once.
REQ-021 The trailer SHALL be byte_count[15:8], byte_count[7:0]; byte_count is the number of payload bytes emitted (16 bits; 0 is legal).
REQ-022 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL hold stable.
REQ-023 seq SHALL increment by 1 after each m_axis_tlast handshake and wrap from 16'hFFFF to 16'h0000.
REQ-024 A new packet SHALL NOT start until the previous m_axis_tlast handshake has completed; back-to-back packets may start on the next cycle.

Reset
REQ-025 Under reset: state=IDLE; s_axis_tready, m_axis_tvalid, m_axis_tlast and m_axis_tdata=0; seq, word count, byte count and checksum=0; word register empty.
REQ-026 Reset asserted mid-packet SHALL abort the packet immediately with no trailer; the next packet SHALL use seq=0.

Configuration
REQ-027 With PKT_CHECKSUM_EN defined, the trailer SHALL append sum[15:8] and sum[7:0] after byte_count (trailer 4 bytes, tlast on sum[7:0]); sum is the modulo-2^16 sum of the emitted payload bytes.
REQ-028 Without PKT_CHECKSUM_EN, the trailer SHALL be 2 bytes, no sum logic SHALL be synthesised, and tlast SHALL be on byte_count[7:0].

Structure
REQ-029 Package pkt_pkg SHALL hold the FSM state enum, HDR_LEN=4, TRL_LEN (2 or 4 according to PKT_CHECKSUM_EN) and the default HDR_MAGIC.
REQ-030 Sub-module pkt_byte_serializer SHALL own the word register, the tkeep lane skipping and the output register slice; the top SHALL own the FSM, counters and seq.

Verification
REQ-031 PKT_WORDS=2, two words 64'h0807060504030201 and 64'h100F0E0D0C0B0A09, tkeep=FF, tready=1 -> bytes A5 5A 00 00 01..10 00 10; with PKT_CHECKSUM_EN, followed by 00 88.
REQ-032 A single word with tkeep=8'h0F and tlast=1 -> payload 01 02 03 04, byte_count 00 04, packet closed before PKT_WORDS is reached.
REQ-033 m_axis_tready toggling 1-0-0-1 every cycle -> no byte lost or duplicated, outputs held stable during stalls, s_axis_tready never high while the word register is full.
REQ-034 seq preloaded to 16'hFFFF via 65535 packets (or a force) -> next header seq bytes FF FF, following header 00 00.
REQ-035 Reset pulsed during the 3rd payload byte -> outputs 0 the next cycle, no tlast, next packet header A5 5A 00 00.
REQ-036 A word with tkeep=00 and tlast=1 -> header, then trailer 00 00 (checksum 00 00), tlast asserted once.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and framing constants for the MM2S byte packetizer.
// Latency: n/a (package only).
// Backpressure: n/a. Optional macro PKT_CHECKSUM_EN widens the trailer to 4 bytes.
package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    TRL     = 2'd3
  } pkt_state_e;

  localparam int HDR_LEN = 4;

`ifdef PKT_CHECKSUM_EN
  localparam int TRL_LEN = 4;
`else
  localparam int TRL_LEN = 2;
`endif

  localparam logic [15:0] DEFAULT_HDR_MAGIC = 16'hA55A;

endpackage

// File: rtl/pkt_byte_serializer.sv
// Word register plus byte output slice: unpacks one 64-bit word lane0..lane7, skipping tkeep=0 lanes.
// Latency: first byte of an accepted word appears 2 cycles after the input handshake; then 1 byte/cycle.
// Backpressure: output slice holds while m_tready=0; s_tready depends only on registered state.
module pkt_byte_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        pay_en,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        ins_vld,
  input  logic [7:0]  ins_dat,
  input  logic        ins_last,
  output logic        ins_rdy,
  input  logic        m_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        pay_emit,
  output logic        word_done,
  output logic        word_last
`ifdef PKT_CHECKSUM_EN
  ,
  output logic [7:0]  pay_byte
`endif
);

  logic [63:0] word_dat_q, word_dat_d;
  logic [7:0]  rem_keep_q, rem_keep_d;
  logic        word_last_q, word_last_d;
  logic        word_full_q, word_full_d;
  logic [7:0]  m_dat_q, m_dat_d;
  logic        m_vld_q, m_vld_d;
  logic        m_last_q, m_last_d;
  logic [2:0]  lane;
  logic [7:0]  lane_byte;
  logic [7:0]  keep_next;

  assign s_tready  = pay_en && !word_full_q;
  assign ins_rdy   = !m_vld_q || m_tready;
  assign m_tdata   = m_dat_q;
  assign m_tvalid  = m_vld_q;
  assign m_tlast   = m_last_q;
  assign word_last = word_last_q;
  assign lane_byte = word_dat_q[{lane, 3'b000} +: 8];
`ifdef PKT_CHECKSUM_EN
  assign pay_byte  = lane_byte;
`endif

  // Pick the lowest lane still pending in the word register.
  always_comb begin
    lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_keep_q[i]) lane = 3'(i);
    end
  end

  // Word register bookkeeping and output slice next-state.
  always_comb begin
    pay_emit    = pay_en && word_full_q && (rem_keep_q != 8'h00) && ins_rdy;
    keep_next   = rem_keep_q;
    if (pay_emit) keep_next[lane] = 1'b0;
    // An all-zero tkeep word finishes immediately without emitting anything.
    word_done   = word_full_q && (keep_next == 8'h00);

    word_dat_d  = word_dat_q;
    rem_keep_d  = keep_next;
    word_last_d = word_last_q;
    word_full_d = word_full_q && !word_done;
    if (s_tvalid && s_tready) begin
      word_dat_d  = s_tdata;
      rem_keep_d  = s_tkeep;
      word_last_d = s_tlast;
      word_full_d = 1'b1;
    end

    m_dat_d  = m_dat_q;
    m_vld_d  = m_vld_q;
    m_last_d = m_last_q;
    if (ins_rdy) begin
      m_vld_d  = 1'b0;
      m_last_d = 1'b0;
      if (ins_vld) begin
        m_dat_d  = ins_dat;
        m_vld_d  = 1'b1;
        m_last_d = ins_last;
      end else if (pay_emit) begin
        m_dat_d  = lane_byte;
        m_vld_d  = 1'b1;
      end
    end
  end

  // Register word state and the output slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_dat_q  <= '0;
      rem_keep_q  <= '0;
      word_last_q <= 1'b0;
      word_full_q <= 1'b0;
      m_dat_q     <= '0;
      m_vld_q     <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      word_dat_q  <= word_dat_d;
      rem_keep_q  <= rem_keep_d;
      word_last_q <= word_last_d;
      word_full_q <= word_full_d;
      m_dat_q     <= m_dat_d;
      m_vld_q     <= m_vld_d;
      m_last_q    <= m_last_d;
    end
  end

endmodule

// File: rtl/mm2s_byte_packetizer.sv
// Frames 64-bit MM2S words into a byte stream: magic, seq, payload, byte_count (+sum with PKT_CHECKSUM_EN).
// Latency: first header byte valid 1 cycle after s_axis_tvalid is seen in IDLE.
// Backpressure: m_axis_tready stalls the output slice; s_axis_tready only in PAYLOAD with an empty word register.
module mm2s_byte_packetizer
  import pkt_pkg::*;
#(
  parameter int          PKT_WORDS = 64,
  parameter logic [15:0] HDR_MAGIC = DEFAULT_HDR_MAGIC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);

  localparam logic [12:0] PKT_WORDS_L = 13'(PKT_WORDS);

  pkt_state_e  state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [12:0] word_cnt_q, word_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [2:0]  trl_idx_q, trl_idx_d;
  logic        ins_vld, ins_last, ins_rdy, pay_en;
  logic [7:0]  ins_dat, hdr_byte, trl_byte;
  logic        pay_emit, word_done, word_last;
`ifdef PKT_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [7:0]  pay_byte;
`endif

  pkt_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .pay_en    (pay_en),
    .s_tdata   (s_axis_tdata),
    .s_tkeep   (s_axis_tkeep),
    .s_tlast   (s_axis_tlast),
    .s_tvalid  (s_axis_tvalid),
    .s_tready  (s_axis_tready),
    .ins_vld   (ins_vld),
    .ins_dat   (ins_dat),
    .ins_last  (ins_last),
    .ins_rdy   (ins_rdy),
    .m_tready  (m_axis_tready),
    .m_tdata   (m_axis_tdata),
    .m_tvalid  (m_axis_tvalid),
    .m_tlast   (m_axis_tlast),
    .pay_emit  (pay_emit),
    .word_done (word_done),
    .word_last (word_last)
`ifdef PKT_CHECKSUM_EN
    ,
    .pay_byte  (pay_byte)
`endif
  );

  // Header byte selected by position: magic high, magic low, seq high, seq low.
  always_comb begin
    case (hdr_idx_q)
      3'd0:    hdr_byte = HDR_MAGIC[15:8];
      3'd1:    hdr_byte = HDR_MAGIC[7:0];
      3'd2:    hdr_byte = seq_q[15:8];
      default: hdr_byte = seq_q[7:0];
    endcase
  end

  // Trailer byte selected by position: byte_count then (optionally) the payload sum.
  always_comb begin
    case (trl_idx_q)
      3'd0:    trl_byte = byte_cnt_q[15:8];
`ifdef PKT_CHECKSUM_EN
      3'd1:    trl_byte = byte_cnt_q[7:0];
      3'd2:    trl_byte = sum_q[15:8];
      default: trl_byte = sum_q[7:0];
`else
      default: trl_byte = byte_cnt_q[7:0];
`endif
    endcase
  end

  // Packet FSM next-state: header/trailer injection, payload counting, close and seq advance.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    hdr_idx_d  = hdr_idx_q;
    trl_idx_d  = trl_idx_q;
`ifdef PKT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    ins_vld    = 1'b0;
    ins_dat    = hdr_byte;
    ins_last   = 1'b0;
    pay_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          ins_vld = 1'b1;
          if (ins_rdy) begin
            hdr_idx_d = 3'd1;
            state_d   = HDR;
          end
        end
      end
      HDR: begin
        if (hdr_idx_q < 3'(HDR_LEN)) begin
          ins_vld = 1'b1;
          if (ins_rdy) hdr_idx_d = hdr_idx_q + 3'd1;
        end else if (m_axis_tvalid && m_axis_tready) begin
          // Last header byte has been taken by the MAC.
          hdr_idx_d = 3'd0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        pay_en = 1'b1;
        if (pay_emit) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef PKT_CHECKSUM_EN
          sum_d      = sum_q + {8'h00, pay_byte};
`endif
        end
        if (word_done) begin
          word_cnt_d = word_cnt_q + 13'd1;
          // tlast and the word limit on the same word still close only once.
          if (word_last || (word_cnt_d == PKT_WORDS_L)) begin
            trl_idx_d = 3'd0;
            state_d   = TRL;
          end
        end
      end
      TRL: begin
        if (trl_idx_q < 3'(TRL_LEN)) begin
          ins_vld  = 1'b1;
          ins_dat  = trl_byte;
          ins_last = (trl_idx_q == 3'(TRL_LEN - 1));
          if (ins_rdy) trl_idx_d = trl_idx_q + 3'd1;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          seq_d      = seq_q + 16'd1;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          trl_idx_d  = 3'd0;
`ifdef PKT_CHECKSUM_EN
          sum_d      = '0;
`endif
          state_d    = IDLE;
        end
      end
    endcase
  end

  // Packet FSM state, counters and seq.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      hdr_idx_q  <= '0;
      trl_idx_q  <= '0;
`ifdef PKT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_idx_q  <= hdr_idx_d;
      trl_idx_q  <= trl_idx_d;
`ifdef PKT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mm2s_byte_packetizer.sv
// Scoreboard bench for mm2s_byte_packetizer with PKT_WORDS=2.
// Stimulus pushes hand-computed expected bytes; a negedge monitor pops and compares on each handshake.
// Also checks reset outputs, stall stability and s_axis_tready versus the word register.
module tb_mm2s_byte_packetizer;

`ifdef PKT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  localparam logic [63:0] W0 = 64'h0807060504030201;
  localparam logic [63:0] W1 = 64'h100F0E0D0C0B0A09;

  logic        clk;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  logic [8:0]  exp_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;
  int          mode = 0;
  int          ph = 0;
  bit          mon_en = 1'b1;
  bit          prev_stall = 1'b0;
  logic [9:0]  held = '0;
  logic [8:0]  exp_b;

  mm2s_byte_packetizer #(.PKT_WORDS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC ready: always high in mode 0, repeating 1-0-0-1 in mode 1.
  initial m_axis_tready = 1'b1;
  always @(posedge clk) begin
    #1;
    ph = ph + 1;
    if (mode == 0) m_axis_tready = 1'b1;
    else           m_axis_tready = ((ph % 4) == 0) || ((ph % 4) == 3);
  end

  // Monitor: all comparisons happen here, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      total++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready} !== 11'd0) begin
        bad++;
        $display("FAIL reset_outputs: got vld=%b last=%b data=%h s_rdy=%b, required all 0",
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready);
      end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== held) begin
          bad++;
          $display("FAIL stall_hold: got %h, required %h", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, held);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
      if (s_axis_tready) begin
        total++;
        if (dut.u_ser.word_full_q !== 1'b0) begin
          bad++;
          $display("FAIL s_rdy_full: s_axis_tready=1 with word register full=%b, required 0",
                   dut.u_ser.word_full_q);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        total++;
        if (!mon_en) begin
          if (m_axis_tlast) begin
            bad++;
            $display("FAIL abort_tlast: got tlast=1 on byte %h, required 0", m_axis_tdata);
          end
        end else if (rd_ptr == wr_ptr) begin
          bad++;
          $display("FAIL unexpected_byte: got last=%b data=%h, required no output", m_axis_tlast, m_axis_tdata);
        end else begin
          exp_b = exp_mem[rd_ptr];
          rd_ptr++;
          if ({m_axis_tlast, m_axis_tdata} !== exp_b) begin
            bad++;
            $display("FAIL byte[%0d]: got last=%b data=%h, required last=%b data=%h",
                     rd_ptr - 1, m_axis_tlast, m_axis_tdata, exp_b[8], exp_b[7:0]);
          end
        end
      end
    end
  end

  task automatic push(input logic last, input logic [7:0] b);
    exp_mem[wr_ptr] = {last, b};
    wr_ptr++;
  endtask

  task automatic push_hdr(input logic [15:0] s);
    push(1'b0, 8'hA5);
    push(1'b0, 8'h5A);
    push(1'b0, s[15:8]);
    push(1'b0, s[7:0]);
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      if (k[i]) push(1'b0, d[8*i +: 8]);
    end
  endtask

  task automatic push_trl(input logic [15:0] cnt, input logic [15:0] sum);
    push(1'b0, cnt[15:8]);
    if (CSUM) begin
      push(1'b0, cnt[7:0]);
      push(1'b0, sum[15:8]);
      push(1'b1, sum[7:0]);
    end else begin
      push(1'b1, cnt[7:0]);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        $display("FAIL send_word_timeout: got no s_axis_tready in %0d cycles, required a handshake", n);
        $fatal(1);
      end
    end while (!s_axis_tready);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (rd_ptr != wr_ptr) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", wr_ptr - rd_ptr);
        $fatal(1);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Two full words closed by the word limit.
    push_hdr(16'h0000); push_word(W0, 8'hFF); push_word(W1, 8'hFF); push_trl(16'h0010, 16'h0088);
    send_word(W0, 8'hFF, 1'b0);
    send_word(W1, 8'hFF, 1'b0);

    // Partial word with tlast closes early.
    push_hdr(16'h0001); push_word(W0, 8'h0F); push_trl(16'h0004, 16'h000A);
    send_word(W0, 8'h0F, 1'b1);

    // Empty word with tlast: header then zero trailer.
    push_hdr(16'h0002); push_trl(16'h0000, 16'h0000);
    send_word(W0, 8'h00, 1'b1);

    // Sparse lanes; tlast and word limit coincide on the second word.
    push_hdr(16'h0003); push_word(W0, 8'hA5); push_word(W1, 8'h80); push_trl(16'h0005, 16'h0022);
    send_word(W0, 8'hA5, 1'b0);
    send_word(W1, 8'h80, 1'b1);
    drain();

    // Same as the first packet under 1-0-0-1 MAC back-pressure.
    mode = 1;
    push_hdr(16'h0004); push_word(W0, 8'hFF); push_word(W1, 8'hFF); push_trl(16'h0010, 16'h0088);
    send_word(W0, 8'hFF, 1'b0);
    send_word(W1, 8'hFF, 1'b0);
    drain();
    mode = 0;

    // seq wrap from FFFF to 0000.
    force dut.seq_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.seq_q;
    push_hdr(16'hFFFF); push_word(W0, 8'h01); push_trl(16'h0001, 16'h0001);
    send_word(W0, 8'h01, 1'b1);
    push_hdr(16'h0000); push_word(W0, 8'h01); push_trl(16'h0001, 16'h0001);
    send_word(W0, 8'h01, 1'b1);
    drain();

    // Reset while the 3rd payload byte is presented; next packet restarts at seq 0.
    mon_en = 1'b0;
    base = hs_cnt;
    send_word(W0, 8'hFF, 1'b1);
    n = 0;
    while (hs_cnt != base + 7) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 2000) begin
        $display("FAIL abort_timeout: got %0d handshakes, required 7", hs_cnt - base);
        $fatal(1);
      end
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    push_hdr(16'h0000); push_word(W0, 8'h03); push_trl(16'h0002, 16'h0003);
    send_word(W0, 8'h03, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2 ms, required $finish");
    $fatal(1);
  end

endmodule
